// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues the instruction-memory read,
// and fills the IF/ID register. Next PC comes from a 2-bit BHT plus a
// direct-mapped BTB when FETCH_BRANCH_PREDICT_EN is defined; otherwise the
// next PC is always pc+4.
// Optional feature macro: FETCH_BRANCH_PREDICT_EN
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h00000060,
   parameter int unsigned INDEX_BITS = 8,
   parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipeline_continue,
   input  logic                  load_use_hazard,
   input  logic                  branch_hazard,
   input  logic                  pc_correction_sel,
   input  logic [31:0]           branch_target,
   input  logic [31:0]           ex_pc,
   input  logic                  ex_is_branch,
   input  logic                  ex_is_jump,
   input  logic                  ex_br_en,
   input  logic [INDEX_BITS-1:0] ex_bp_index,
   output logic [31:0]           imem_addr,
   output logic                  imem_read,
   input  logic [31:0]           imem_rdata,
   output logic [31:0]           id_pc,
   output logic [31:0]           id_instr,
   output logic [INDEX_BITS-1:0] id_bp_index,
   output logic                  id_pred_taken
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam int unsigned TAG_W   = 32 - INDEX_BITS - 2;

   logic [31:0]           pc;
   logic [31:0]           pc_plus4;
   logic [31:0]           pred_next;
   logic                  pred_taken;
   logic [INDEX_BITS-1:0] idx;

   assign idx       = pc[INDEX_BITS+1:2];
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign imem_read = ~rst;

`ifdef FETCH_BRANCH_PREDICT_EN
   logic [1:0]       bht        [ENTRIES];
   logic             btb_valid  [ENTRIES];
   logic [TAG_W-1:0] btb_tag    [ENTRIES];
   logic [31:0]      btb_target [ENTRIES];
   logic             btb_is_jump[ENTRIES];

   logic [TAG_W-1:0] tag;
   logic             hit;
   logic             btb_write;

   assign tag       = pc[31:INDEX_BITS+2];
   assign btb_write = (ex_is_branch && ex_br_en) || ex_is_jump;

   // Lookup: taken when the BTB hits and the entry is a jump or the counter says taken
   always_comb begin
      hit        = btb_valid[idx] && (btb_tag[idx] == tag);
      pred_taken = hit && (btb_is_jump[idx] || bht[idx][1]);
      pred_next  = pred_taken ? btb_target[idx] : pc_plus4;
   end

   // Counters and valid bits: reset to weakly-not-taken / empty, trained from EX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            bht[INDEX_BITS'(i)]       <= 2'b01;
            btb_valid[INDEX_BITS'(i)] <= 1'b0;
         end
      end else if (pipeline_continue) begin
         if (ex_is_branch) begin
            if (ex_br_en && (bht[ex_bp_index] != 2'b11))
               bht[ex_bp_index] <= bht[ex_bp_index] + 2'b01;
            else if (!ex_br_en && (bht[ex_bp_index] != 2'b00))
               bht[ex_bp_index] <= bht[ex_bp_index] - 2'b01;
         end
         if (btb_write)
            btb_valid[ex_bp_index] <= 1'b1;
      end
   end

   // BTB payload; meaningless until the matching valid bit is set
   always_ff @(posedge clk) begin
      if (pipeline_continue && btb_write) begin
         btb_tag[ex_bp_index]     <= ex_pc[31:INDEX_BITS+2];
         btb_target[ex_bp_index]  <= branch_target;
         btb_is_jump[ex_bp_index] <= ex_is_jump;
      end
   end
`else
   logic unused_train;

   assign unused_train = ^{ex_is_branch, ex_is_jump, ex_br_en, ex_bp_index};

   // No predictor: always fall through
   always_comb begin
      pred_taken = 1'b0;
      pred_next  = pc_plus4;
   end
`endif

   // PC and IF/ID register: stall, flush, load-use hold, then normal advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= RESET_PC;
         id_pc         <= 32'd0;
         id_instr      <= NOP_INSTR;
         id_bp_index   <= '0;
         id_pred_taken <= 1'b0;
      end else if (pipeline_continue) begin
         if (branch_hazard) begin
            pc            <= pc_correction_sel ? (ex_pc + 32'd4) : branch_target;
            id_pc         <= pc;
            id_instr      <= NOP_INSTR;
            id_pred_taken <= 1'b0;
         end else if (load_use_hazard) begin
            pc            <= pred_next;
            id_pc         <= pc;
            id_instr      <= imem_rdata;
            id_bp_index   <= idx;
            id_pred_taken <= pred_taken;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;

   localparam int unsigned IB = 8;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] RPC = 32'h00000060;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pipeline_continue = 1'b1;
   logic          load_use_hazard = 1'b1;
   logic          branch_hazard = 1'b0;
   logic          pc_correction_sel = 1'b0;
   logic [31:0]   branch_target = 32'd0;
   logic [31:0]   ex_pc = 32'd0;
   logic          ex_is_branch = 1'b0;
   logic          ex_is_jump = 1'b0;
   logic          ex_br_en = 1'b0;
   logic [IB-1:0] ex_bp_index = '0;
   logic [31:0]   imem_addr;
   logic          imem_read;
   logic [31:0]   imem_rdata;
   logic [31:0]   id_pc;
   logic [31:0]   id_instr;
   logic [IB-1:0] id_bp_index;
   logic          id_pred_taken;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .pipeline_continue(pipeline_continue), .load_use_hazard(load_use_hazard),
      .branch_hazard(branch_hazard), .pc_correction_sel(pc_correction_sel),
      .branch_target(branch_target), .ex_pc(ex_pc),
      .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_br_en(ex_br_en),
      .ex_bp_index(ex_bp_index),
      .imem_addr(imem_addr), .imem_read(imem_read), .imem_rdata(imem_rdata),
      .id_pc(id_pc), .id_instr(id_instr), .id_bp_index(id_bp_index),
      .id_pred_taken(id_pred_taken)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F81;
   endfunction

   assign imem_rdata = mem_fn(imem_addr);

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_id_pc, m_id_instr;
   int          m_id_idx;
   bit          m_id_pt;
   int          m_bht [256];
   bit          m_valid [256];
   logic [31:0] m_tag [256];
   logic [31:0] m_tgt [256];
   bit          m_jump [256];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = RPC; m_id_pc = 32'd0; m_id_instr = NOP; m_id_idx = 0; m_id_pt = 0;
         for (int i = 0; i < 256; i++) begin
            m_bht[i] = 1; m_valid[i] = 0;
         end
      end else if (pipeline_continue) begin
         int          idx;
         bit          pt;
         logic [31:0] nxt;
         idx = int'((m_pc >> 2) % 256);
         pt  = 0;
         nxt = m_pc + 32'd4;
`ifdef FETCH_BRANCH_PREDICT_EN
         if (m_valid[idx] && m_tag[idx] == (m_pc >> 10) && (m_jump[idx] || m_bht[idx] >= 2)) begin
            pt  = 1;
            nxt = m_tgt[idx];
         end
`endif
         if (branch_hazard) begin
            m_id_pc = m_pc; m_id_instr = NOP; m_id_pt = 0;
            m_pc = pc_correction_sel ? ex_pc + 32'd4 : branch_target;
         end else if (load_use_hazard) begin
            m_id_pc = m_pc; m_id_instr = mem_fn(m_pc); m_id_idx = idx; m_id_pt = pt;
            m_pc = nxt;
         end
`ifdef FETCH_BRANCH_PREDICT_EN
         if (ex_is_branch) begin
            int e;
            e = int'(ex_bp_index);
            m_bht[e] = ex_br_en ? ((m_bht[e] + 1 > 3) ? 3 : m_bht[e] + 1)
                                : ((m_bht[e] - 1 < 0) ? 0 : m_bht[e] - 1);
         end
         if ((ex_is_branch && ex_br_en) || ex_is_jump) begin
            int e;
            e = int'(ex_bp_index);
            m_valid[e] = 1; m_tag[e] = ex_pc >> 10; m_tgt[e] = branch_target; m_jump[e] = ex_is_jump;
         end
`endif
      end
   end

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endfunction

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("imem_read", 32'(imem_read), 32'(!rst));
         chk("id_pc", id_pc, m_id_pc);
         chk("id_instr", id_instr, m_id_instr);
         chk("id_bp_index", 32'(id_bp_index), 32'(m_id_idx));
         chk("id_pred_taken", 32'(id_pred_taken), 32'(m_id_pt));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipeline_continue = 1; load_use_hazard = 1; branch_hazard = 0; pc_correction_sel = 0;
      ex_is_branch = 0; ex_is_jump = 0; ex_br_en = 0;
   endtask

   task automatic redirect(input logic [31:0] t);
      idle();
      branch_hazard = 1; branch_target = t;
      tick();
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      cmp_en = 1;
      #1;
      chk("rst_addr", imem_addr, 32'h60);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, NOP);
      chk("rst_read", 32'(imem_read), 32'd1);
      repeat (3) tick();
      chk("adv_id_pc", id_pc, 32'h68);
      chk("adv_pc", imem_addr, 32'h6C);
      chk("adv_pred", 32'(id_pred_taken), 32'd0);

      // stall at 0x80 with a pending hazard that must wait
      redirect(32'h80);
      pipeline_continue = 0; branch_hazard = 1; branch_target = 32'h3FC;
      repeat (4) tick();
      chk("stall_pc", imem_addr, 32'h80);
      chk("stall_id_pc", id_pc, 32'h6C);
      pipeline_continue = 1;
      tick();
      chk("stall_release_pc", imem_addr, 32'h3FC);

      // load-use hold at 0x90, then hazard overrides the hold
      redirect(32'h90);
      load_use_hazard = 0;
      tick();
      chk("lu_pc", imem_addr, 32'h90);
      chk("lu_instr", id_instr, NOP);
      branch_hazard = 1; branch_target = 32'h200;
      tick();
      chk("lu_bh_pc", imem_addr, 32'h200);
      chk("lu_bh_instr", id_instr, NOP);
      idle();

      // train a taken branch at 0x100 -> 0x180 twice
      ex_is_branch = 1; ex_br_en = 1; ex_pc = 32'h100; ex_bp_index = 8'h40; branch_target = 32'h180;
      repeat (2) tick();
      redirect(32'h100);
      tick();
      chk("bp_id_pc", id_pc, 32'h100);
`ifdef FETCH_BRANCH_PREDICT_EN
      chk("bp_pred", 32'(id_pred_taken), 32'd1);
      chk("bp_pc", imem_addr, 32'h180);
`else
      chk("bp_pred", 32'(id_pred_taken), 32'd0);
      chk("bp_pc", imem_addr, 32'h104);
`endif
      // not-taken resolution, correct to ex_pc+4
      branch_hazard = 1; pc_correction_sel = 1; ex_pc = 32'h100;
      ex_is_branch = 1; ex_br_en = 0; ex_bp_index = 8'h40;
      tick();
      idle();
      chk("nt_pc", imem_addr, 32'h104);
`ifdef FETCH_BRANCH_PREDICT_EN
      chk("nt_model_ctr", 32'(m_bht[8'h40]), 32'd2);
`endif

      // jal at 0x300 -> 0x40
      ex_is_jump = 1; ex_pc = 32'h300; ex_bp_index = 8'hC0; branch_target = 32'h40;
      tick();
      redirect(32'h300);
      tick();
`ifdef FETCH_BRANCH_PREDICT_EN
      chk("jal_pc", imem_addr, 32'h40);
      chk("jal_pred", 32'(id_pred_taken), 32'd1);
`else
      chk("jal_pc", imem_addr, 32'h304);
`endif

      // aliasing: 0x500 shares index 0x40 with 0x100 but not the tag
      redirect(32'h500);
      tick();
      chk("alias_pc", imem_addr, 32'h504);
      chk("alias_pred", 32'(id_pred_taken), 32'd0);

      // reset in the middle of a flush
      branch_hazard = 1; branch_target = 32'h7777_0000;
      #2 rst = 1;
      #1 rst = 0;
      idle();
      #1;
      chk("midrst_pc", imem_addr, RPC);
      tick();
      chk("midrst_adv_pc", imem_addr, 32'h64);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         pipeline_continue = ($urandom_range(0, 9) != 0);
         load_use_hazard   = ($urandom_range(0, 6) != 0);
         branch_hazard     = ($urandom_range(0, 9) == 0);
         pc_correction_sel = $urandom_range(0, 1) == 1;
         ex_pc             = ($urandom_range(0, 1) == 1) ? imem_addr : (32'($urandom_range(0, 32'h7FF)) << 2);
         if ($urandom_range(0, 15) == 0)
            ex_pc = ex_pc | 32'hFFFF_F000;
         ex_bp_index       = ex_pc[IB+1:2];
         branch_target     = ($urandom_range(0, 3) == 0) ? ex_pc : (32'($urandom_range(0, 32'h7FF)) << 2);
         ex_is_branch      = ($urandom_range(0, 2) == 0);
         ex_br_en          = ($urandom_range(0, 2) != 0);
         ex_is_jump        = !ex_is_branch && ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1;
            #1 rst = 0;
         end
         tick();
      end

      idle();
      tick();
      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
